// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed 7-segment scanner: a prescaler steps a digit index,
// a per-frame snapshot of the counter bank feeds per-digit decoders.

module seg_scan_digit #(
  parameter int unsigned IDX = 0
) (
  input  logic [3:0] val,
  input  logic       upper_zero,
  input  logic       blank_en,
  output logic       blank,
  output logic [6:0] hex
);
  // Digit 0 always shows something, even when the whole display is zero.
  assign blank = (IDX != 0) && blank_en && upper_zero;

  always_comb begin
    hex = 7'h7F;
    case (val)
      4'h0: hex = 7'h40;
      4'h1: hex = 7'h79;
      4'h2: hex = 7'h24;
      4'h3: hex = 7'h30;
      4'h4: hex = 7'h19;
      4'h5: hex = 7'h12;
      4'h6: hex = 7'h02;
      4'h7: hex = 7'h78;
      4'h8: hex = 7'h00;
      4'h9: hex = 7'h10;
      4'hA: hex = 7'h08;
      4'hB: hex = 7'h03;
      4'hC: hex = 7'h46;
      4'hD: hex = 7'h21;
      4'hE: hex = 7'h06;
      4'hF: hex = 7'h0E;
      default: hex = 7'h7F;
    endcase
  end
endmodule

module seg_scan_driver #(
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic       input_clk,
  input  logic       rst,
  input  logic [3:0] cnt0,
  input  logic [3:0] cnt1,
  input  logic [3:0] cnt2,
  input  logic [3:0] cnt3,
  input  logic       blank_en,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       frame_done
);
  localparam int unsigned NUM_DIG = 4;
  localparam int unsigned PW      = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] LAST  = PW'(SCAN_DIV - 1);

  logic [PW-1:0]                presc;
  logic [1:0]                   idx;
  logic [NUM_DIG-1:0][3:0]      snap;
  logic [NUM_DIG-1:0]           blank;
  logic [NUM_DIG-1:0][6:0]      hex;
  logic                         tick;
  logic                         wrap;

  assign tick = (presc == LAST);
  assign wrap = tick && (idx == 2'd3);

  // Blanking of digit g depends on digits g..3 all being zero in the snapshot.
  for (genvar g = 0; g < NUM_DIG; g++) begin : g_dig
    seg_scan_digit #(.IDX(g)) u_dig (
      .val        (snap[g]),
      .upper_zero (~|snap[NUM_DIG-1:g]),
      .blank_en   (blank_en),
      .blank      (blank[g]),
      .hex        (hex[g])
    );
  end

  always_ff @(posedge input_clk or negedge rst) begin
    if (!rst) begin
      presc      <= '0;
      idx        <= '0;
      snap       <= '0;
      an         <= 4'hF;
      seg        <= 7'h7F;
      frame_done <= 1'b0;
    end else begin
      presc <= tick ? '0 : presc + PW'(1);
      if (tick) idx <= idx + 2'd1;
      // Capture the whole bank at frame end so one frame never mixes counts.
      if (wrap) snap <= {cnt3, cnt2, cnt1, cnt0};
      an         <= blank[idx] ? 4'hF : ~(4'b0001 << idx);
      seg        <= blank[idx] ? 7'h7F : hex[idx];
      frame_done <= wrap;
    end
  end
endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed plus randomized checks of seg_scan_driver against a cycle-count
// reference model (SCAN_DIV=4, 16-cycle frames).

module tb_seg_scan_driver;
  localparam int SCAN_DIV = 4;
  localparam int FRAME    = 4 * SCAN_DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] cnt0 = '0, cnt1 = '0, cnt2 = '0, cnt3 = '0;
  logic       blank_en = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       frame_done;

  int n_cmp = 0;
  int n_bad = 0;
  int n     = 0;          // edges since reset release
  logic [15:0] m_snap = '0;

  logic [6:0] seg_lut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seg_scan_driver #(.SCAN_DIV(SCAN_DIV)) dut (
    .input_clk (clk),
    .rst       (rst),
    .cnt0      (cnt0),
    .cnt1      (cnt1),
    .cnt2      (cnt2),
    .cnt3      (cnt3),
    .blank_en  (blank_en),
    .an        (an),
    .seg       (seg),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Expected {an,seg} for digit position d of a snapshot.
  function automatic logic [10:0] model_out(input int d, input logic [15:0] s, input logic bl);
    logic [15:0] upper;
    logic [3:0]  v;
    logic        blanked;
    logic [3:0]  a;
    upper   = s >> (4 * d);
    v       = upper[3:0];
    blanked = (d != 0) && bl && (upper == 16'h0);
    a       = 4'hF;
    if (!blanked) a[d] = 1'b0;
    return {a, blanked ? 7'h7F : seg_lut[v]};
  endfunction

  // One clock edge: model advances from the pre-edge state, then outputs are checked.
  task automatic step();
    logic [10:0] e;
    logic        fd_e;
    @(posedge clk);
    e    = model_out((n / SCAN_DIV) % 4, m_snap, blank_en);
    n++;
    fd_e = (n % FRAME) == 0;
    if (fd_e) m_snap = {cnt3, cnt2, cnt1, cnt0};
    #1;
    chk("model_an", {3'b0, an}, {3'b0, e[10:7]});
    chk("model_seg", seg, e[6:0]);
    chk("model_fd", {6'b0, frame_done}, {6'b0, fd_e});
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_an"}, {3'b0, an}, 7'h0F);
    chk({tag, "_seg"}, seg, 7'h7F);
    chk({tag, "_fd"}, {6'b0, frame_done}, 7'h00);
  endtask

  // Asynchronous reset mid-cycle, held across two edges, released on a falling edge.
  task automatic do_reset();
    #3 rst = 1'b0;
    #1 chk_reset_state("async_rst");
    repeat (2) @(posedge clk);
    #1 chk_reset_state("held_rst");
    @(negedge clk);
    rst    = 1'b1;
    n      = 0;
    m_snap = '0;
  endtask

  task automatic to_frame_start();
    while ((n % FRAME) != 0) step();
  endtask

  // One whole frame checked against fixed per-digit constants.
  task automatic frame_check(input string tag, input logic [3:0][3:0] ean,
                             input logic [3:0][6:0] eseg);
    for (int k = 0; k < FRAME; k++) begin
      step();
      chk({tag, "_an"}, {3'b0, an}, {3'b0, ean[k / SCAN_DIV]});
      chk({tag, "_seg"}, seg, eseg[k / SCAN_DIV]);
    end
  endtask

  initial begin
    #12 chk_reset_state("por");
    {cnt3, cnt2, cnt1, cnt0} = 16'h4321;
    @(negedge clk);
    rst = 1'b1;

    // First edge after release shows digit 0 as 0.
    step();
    chk("first_an", {3'b0, an}, 7'h0E);
    chk("first_seg", seg, 7'h40);
    to_frame_start();
    chk("first_fd", {6'b0, frame_done}, 7'h01);

    // Scan of 4,3,2,1; cnt0 changes mid-frame but this frame keeps the snapshot.
    for (int k = 0; k < FRAME; k++) begin
      logic [3:0][3:0] ean;
      logic [3:0][6:0] eseg;
      ean  = {4'h7, 4'hB, 4'hD, 4'hE};
      eseg = {7'h19, 7'h30, 7'h24, 7'h79};
      step();
      chk("scan_an", {3'b0, an}, {3'b0, ean[k / SCAN_DIV]});
      chk("scan_seg", seg, eseg[k / SCAN_DIV]);
      if (k == 1) cnt0 = 4'h7;
    end
    frame_check("snap_next", {4'h7, 4'hB, 4'hD, 4'hE}, {7'h19, 7'h30, 7'h24, 7'h78});

    // Leading-zero blanking of digits 3 and 2.
    {cnt3, cnt2, cnt1, cnt0} = 16'h0050;
    blank_en = 1'b1;
    step();
    to_frame_start();
    frame_check("blank", {4'hF, 4'hF, 4'hD, 4'hE}, {7'h7F, 7'h7F, 7'h12, 7'h40});

    // All zero: only digit 0 lit; then F on digit 2.
    {cnt3, cnt2, cnt1, cnt0} = 16'h0000;
    step();
    to_frame_start();
    frame_check("allzero", {4'hF, 4'hF, 4'hF, 4'hE}, {7'h7F, 7'h7F, 7'h7F, 7'h40});
    cnt2 = 4'hF;
    step();
    to_frame_start();
    frame_check("hexf", {4'hF, 4'hB, 4'hD, 4'hE}, {7'h7F, 7'h0E, 7'h40, 7'h40});

    // Reset two edges before the wrap: no pulse, frame restarts from digit 0.
    blank_en = 1'b0;
    {cnt3, cnt2, cnt1, cnt0} = 16'hA5C3;
    while ((n % FRAME) != FRAME - 2) step();
    do_reset();
    step();
    chk("rst_restart_an", {3'b0, an}, 7'h0E);
    chk("rst_restart_seg", seg, 7'h40);
    repeat (2 * FRAME + 3) step();

    // Randomized counts and blank enable, with one random mid-frame reset.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        cnt0 = 4'($urandom); cnt1 = 4'($urandom);
        cnt2 = 4'($urandom); cnt3 = 4'($urandom);
        if ($urandom_range(0, 1) == 0) cnt3 = 4'h0;
        if ($urandom_range(0, 1) == 0) cnt2 = 4'h0;
      end
      if ($urandom_range(0, 4) == 0) blank_en = ~blank_en;
      if (i == 200) do_reset();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
